// File: rtl/face_bbox_locate.sv
// Face bounding-box locator: accumulates qualified skin runs over a frame and
// reports the box, qualifying-row extent and skin pixel count once per frame.
module face_bbox_locate #(
  parameter int H_PIXEL  = 640,
  parameter int V_PIXEL  = 480,
  parameter int MIN_RUN  = 8,
  parameter int MIN_ROWS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_vsync,
  input  logic        pix_href,
  input  logic        pix_valid,
  input  logic        face_bit,
  output logic        box_valid,
  output logic        face_found,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [8:0]  y_min,
  output logic [8:0]  y_max,
  output logic [18:0] pixel_count
);

  localparam int XCW = $clog2(H_PIXEL + 1);
  localparam int YCW = $clog2(V_PIXEL + 1);
  localparam int RW  = $clog2(MIN_RUN + 1);

  localparam logic [XCW-1:0] H_LIM   = XCW'(H_PIXEL);
  localparam logic [XCW-1:0] RUN_OFF = XCW'(MIN_RUN - 1);
  localparam logic [YCW-1:0] V_LIM   = YCW'(V_PIXEL);
  localparam logic [YCW-1:0] ROWS_TH = YCW'(MIN_ROWS);
  localparam logic [RW-1:0]  RUN_MAX = RW'(MIN_RUN);
  localparam logic [RW-1:0]  RUN_PRE = RW'(MIN_RUN - 1);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, REPORT} state_t;

  function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t          state_q, state_d;
  logic            vsync_q, href_q;
  logic [XCW-1:0]  x_q, x_d;
  logic [YCW-1:0]  y_q, y_d;
  logic [RW-1:0]   run_q, run_d;
  logic            row_qual_q, row_qual_d;
  logic [9:0]      xmin_acc_q, xmin_acc_d, xmax_acc_q, xmax_acc_d;
  logic [8:0]      ymin_acc_q, ymin_acc_d, ymax_acc_q, ymax_acc_d;
  logic [YCW-1:0]  rows_q, rows_d;
  logic [18:0]     cnt_q, cnt_d;
  logic            box_valid_q, box_valid_d, face_q, face_d;
  logic [9:0]      xmin_o_q, xmin_o_d, xmax_o_q, xmax_o_d;
  logic [8:0]      ymin_o_q, ymin_o_d, ymax_o_q, ymax_o_d;
  logic [18:0]     cnt_o_q, cnt_o_d;

  logic vs_rise, vs_fall, href_fall, pix, pix_in;
  logic [XCW-1:0] run_start;

  assign vs_rise   = frame_vsync & ~vsync_q;
  assign vs_fall   = ~frame_vsync & vsync_q;
  assign href_fall = href_q & ~pix_href;
  // A pixel arriving with vsync high (including its rising edge) is dropped.
  assign pix       = (state_q == ACTIVE) & pix_valid & pix_href & ~frame_vsync;
  assign pix_in    = pix & (x_q < H_LIM) & (y_q < V_LIM);
  assign run_start = x_q - RUN_OFF;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    run_d       = run_q;
    row_qual_d  = row_qual_q;
    xmin_acc_d  = xmin_acc_q;
    xmax_acc_d  = xmax_acc_q;
    ymin_acc_d  = ymin_acc_q;
    ymax_acc_d  = ymax_acc_q;
    rows_d      = rows_q;
    cnt_d       = cnt_q;
    box_valid_d = 1'b0;
    face_d      = face_q;
    xmin_o_d    = xmin_o_q;
    xmax_o_d    = xmax_o_q;
    ymin_o_d    = ymin_o_q;
    ymax_o_d    = ymax_o_q;
    cnt_o_d     = cnt_o_q;

    case (state_q)
      IDLE: begin
        if (frame_vsync) state_d = SYNC;
      end
      SYNC: begin
        x_d        = '0;
        y_d        = '0;
        run_d      = '0;
        row_qual_d = 1'b0;
        xmin_acc_d = '1;
        xmax_acc_d = '0;
        ymin_acc_d = '0;
        ymax_acc_d = '0;
        rows_d     = '0;
        cnt_d      = '0;
        if (vs_fall) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (pix && (x_q < H_LIM)) x_d = x_q + XCW'(1);
        if (pix_in) begin
          if (face_bit) begin
            cnt_d = cnt_q + 19'd1;
            if (run_q == RUN_PRE) begin
              run_d      = RUN_MAX;
              row_qual_d = 1'b1;
              xmin_acc_d = min10(xmin_acc_q, 10'(run_start));
              xmax_acc_d = max10(xmax_acc_q, 10'(x_q));
            end else if (run_q == RUN_MAX) begin
              xmax_acc_d = max10(xmax_acc_q, 10'(x_q));
            end else begin
              run_d = run_q + RW'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        // End of line: a normal href fall, or vsync cutting the line short.
        if (href_fall || vs_rise) begin
          run_d      = '0;
          row_qual_d = 1'b0;
          if (row_qual_q) begin
            if (rows_q == '0) ymin_acc_d = 9'(y_q);
            ymax_acc_d = 9'(y_q);
            rows_d     = rows_q + YCW'(1);
          end
        end
        if (href_fall) begin
          x_d = '0;
          if (y_q < V_LIM) y_d = y_q + YCW'(1);
        end
        if (vs_rise) state_d = REPORT;
      end
      REPORT: begin
        box_valid_d = 1'b1;
        cnt_o_d     = cnt_q;
        if (rows_q >= ROWS_TH) begin
          face_d   = 1'b1;
          xmin_o_d = xmin_acc_q;
          xmax_o_d = xmax_acc_q;
          ymin_o_d = ymin_acc_q;
          ymax_o_d = ymax_acc_q;
        end else begin
          face_d   = 1'b0;
          xmin_o_d = '0;
          xmax_o_d = '0;
          ymin_o_d = '0;
          ymax_o_d = '0;
        end
        state_d = SYNC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      run_q       <= '0;
      row_qual_q  <= 1'b0;
      xmin_acc_q  <= '0;
      xmax_acc_q  <= '0;
      ymin_acc_q  <= '0;
      ymax_acc_q  <= '0;
      rows_q      <= '0;
      cnt_q       <= '0;
      box_valid_q <= 1'b0;
      face_q      <= 1'b0;
      xmin_o_q    <= '0;
      xmax_o_q    <= '0;
      ymin_o_q    <= '0;
      ymax_o_q    <= '0;
      cnt_o_q     <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= frame_vsync;
      href_q      <= pix_href;
      x_q         <= x_d;
      y_q         <= y_d;
      run_q       <= run_d;
      row_qual_q  <= row_qual_d;
      xmin_acc_q  <= xmin_acc_d;
      xmax_acc_q  <= xmax_acc_d;
      ymin_acc_q  <= ymin_acc_d;
      ymax_acc_q  <= ymax_acc_d;
      rows_q      <= rows_d;
      cnt_q       <= cnt_d;
      box_valid_q <= box_valid_d;
      face_q      <= face_d;
      xmin_o_q    <= xmin_o_d;
      xmax_o_q    <= xmax_o_d;
      ymin_o_q    <= ymin_o_d;
      ymax_o_q    <= ymax_o_d;
      cnt_o_q     <= cnt_o_d;
    end
  end

  assign box_valid   = box_valid_q;
  assign face_found  = face_q;
  assign x_min       = xmin_o_q;
  assign x_max       = xmax_o_q;
  assign y_min       = ymin_o_q;
  assign y_max       = ymax_o_q;
  assign pixel_count = cnt_o_q;

endmodule

// File: tb/tb_face_bbox_locate.sv
// Scoreboard bench for face_bbox_locate on a reduced 64x40 frame
// (MIN_RUN=8, MIN_ROWS=4) so every scenario fits a short run.
module tb_face_bbox_locate;

  logic        clk = 1'b0;
  logic        rst, frame_vsync, pix_href, pix_valid, face_bit;
  logic        box_valid, face_found;
  logic [9:0]  x_min, x_max;
  logic [8:0]  y_min, y_max;
  logic [18:0] pixel_count;

  face_bbox_locate #(
    .H_PIXEL(64), .V_PIXEL(40), .MIN_RUN(8), .MIN_ROWS(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_vsync(frame_vsync), .pix_href(pix_href),
    .pix_valid(pix_valid), .face_bit(face_bit), .box_valid(box_valid),
    .face_found(face_found), .x_min(x_min), .x_max(x_max), .y_min(y_min),
    .y_max(y_max), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int face; int xmin; int xmax; int ymin; int ymax; int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int f, input int x0, input int x1, input int y0,
                      input int y1, input int c);
    exp_t e;
    e.face = f; e.xmin = x0; e.xmax = x1; e.ymin = y0; e.ymax = y1; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_box_valid"}, int'(box_valid), 0);
    chk({tag, "_face_found"}, int'(face_found), 0);
    chk({tag, "_x_min"}, int'(x_min), 0);
    chk({tag, "_x_max"}, int'(x_max), 0);
    chk({tag, "_y_min"}, int'(y_min), 0);
    chk({tag, "_pixel_count"}, int'(pixel_count), 0);
  endtask

  function automatic logic skin(input int mode, input int x, input int y,
                                input int x0, input int x1, input int y0, input int y1);
    if (mode == 1) return (x % 10) < 7;
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  // One frame: vsync blanking, then nlines lines of linelen pixels. A pixel gap
  // is inserted at x==32. tr_line/tr_px raise vsync mid-line; rst_line pulses rst.
  task automatic do_frame(input int nlines, input int linelen, input int mode,
                          input int x0, input int x1, input int y0, input int y1,
                          input int tr_line, input int tr_px, input int rst_line);
    bit stop;
    frame_vsync = 1'b1;
    repeat (8) tick;
    frame_vsync = 1'b0;
    repeat (4) tick;
    stop = 1'b0;
    for (int y = 0; y < nlines && !stop; y++) begin
      pix_href = 1'b1;
      for (int x = 0; x < linelen && !stop; x++) begin
        if (y == tr_line && x == tr_px) begin
          stop = 1'b1;
        end else begin
          if (x == 32) begin
            pix_valid = 1'b0;
            tick;
          end
          if (y == rst_line && x == 20) begin
            pix_valid = 1'b0;
            rst = 1'b1;
            tick;
            tick;
            rst = 1'b0;
            chk_outputs_zero("midreset");
          end
          pix_valid = 1'b1;
          face_bit  = skin(mode, x, y, x0, x1, y0, y1);
          tick;
        end
      end
      pix_valid = 1'b0;
      face_bit  = 1'b0;
      if (!stop) begin
        pix_href = 1'b0;
        repeat (4) tick;
      end
    end
    frame_vsync = 1'b1;
    tick;
    pix_href = 1'b0;
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (box_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_box_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("face_found", int'(face_found), e.face);
          chk("x_min", int'(x_min), e.xmin);
          chk("x_max", int'(x_max), e.xmax);
          chk("y_min", int'(y_min), e.ymin);
          chk("y_max", int'(y_max), e.ymax);
          chk("pixel_count", int'(pixel_count), e.cnt);
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; frame_vsync = 1'b0; pix_href = 1'b0; pix_valid = 1'b0; face_bit = 1'b0;
    repeat (3) tick;
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (3) tick;

    // Empty frame: no lines at all.
    push(0, 0, 0, 0, 0, 0);
    do_frame(0, 64, 0, 0, -1, 0, -1, -1, -1, -1);
    // Solid block x 10..29, y 5..14.
    push(1, 10, 29, 5, 14, 200);
    do_frame(40, 64, 0, 10, 29, 5, 14, -1, -1, -1);
    // Reset during line 20 aborts the frame; no report expected for it.
    do_frame(40, 64, 0, 10, 29, 5, 14, -1, -1, 20);
    push(1, 10, 29, 5, 14, 200);
    do_frame(40, 64, 0, 10, 29, 5, 14, -1, -1, -1);
    // Runs of 7 (and a trailing 4) on every line never qualify: 46 per line.
    push(0, 0, 0, 0, 0, 1840);
    do_frame(40, 64, 1, 0, 0, 0, 0, -1, -1, -1);
    // Three qualifying rows is one short of MIN_ROWS; four is enough.
    push(0, 0, 0, 0, 0, 60);
    do_frame(40, 64, 0, 30, 49, 20, 22, -1, -1, -1);
    push(1, 30, 49, 20, 23, 80);
    do_frame(40, 64, 0, 30, 49, 20, 23, -1, -1, -1);
    // Rows 27..29 full, row 30 cut by vsync after x 0..14 (10 skin pixels).
    push(1, 5, 24, 27, 30, 70);
    do_frame(40, 64, 0, 5, 24, 27, 30, 30, 15, -1);
    // 70 skin pixels per line: only 64 columns are in bounds.
    push(1, 0, 63, 0, 39, 2560);
    do_frame(40, 70, 0, 0, 69, 0, 39, -1, -1, -1);

    repeat (20) tick;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      tick;
      waited++;
    end
    chk("pending_reports", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
